cache_line_buffer: RTL and testbench

//  Line-fill buffer between the main-memory read port and the L1 instruction memory.
//  - FILL phase: collects WORDS words of one cache line as the cache controller strobes
//    we_cl/next_cl on each mem_valid_mm beat.
//  - DRAIN phase: replays the words one per next_cl strobe, with the imem write address,

---
 rtl/cache_line_buffer.sv | 111 +++++++++++
 tb/tb_cache_line_buffer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cache_line_buffer.sv
// Line-fill buffer between the main-memory read port and the L1 instruction memory.
// FILL collects WORDS words of one line; DRAIN replays them with the imem write address.
// A single slot index is shared by both phases; full_cl marks the last slot.
module cache_line_buffer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned WORDS   = 4,
  parameter int unsigned LINE_AW = 28
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clr,
  input  logic                               we_cl,
  input  logic                               next_cl,
  input  logic [DATA_W-1:0]                  din,
  input  logic [LINE_AW-1:0]                 miss_line_addr,
  output logic                               full_cl,
  output logic [DATA_W-1:0]                  dout,
  output logic [LINE_AW+$clog2(WORDS)-1:0]   imem_waddr,
  output logic                               draining,
  output logic                               ovf_err
);

  localparam int unsigned IdxW = $clog2(WORDS);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(WORDS - 1);

  typedef enum logic [0:0] {StFill, StDrain} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [LINE_AW-1:0]    line_addr_q, line_addr_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_W-1:0]     slot_q [WORDS];
  logic                  wr_en;
  logic                  at_last;

  assign at_last = (idx_q == IdxLast);

  // State register: reset and clr both return to an empty FILL with cleared slots.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      state_q     <= StFill;
      idx_q       <= '0;
      line_addr_q <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      line_addr_q <= line_addr_d;
      ovf_q       <= ovf_d;
      if (wr_en) begin
        slot_q[idx_q] <= din;
      end
    end
  end

  // Next-state logic: slot advance, line address capture, phase change and error tracking.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    line_addr_d = line_addr_q;
    ovf_d       = ovf_q;
    wr_en       = 1'b0;
    unique case (state_q)
      StFill: begin
        if (we_cl) begin
          // A write without advance just overwrites the current slot.
          wr_en = 1'b1;
          if (next_cl) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == '0) begin
              line_addr_d = miss_line_addr;
            end
            if (at_last) begin
              state_d = StDrain;
            end
          end
        end else if (next_cl) begin
          // Advancing an unwritten slot would replay garbage; refuse and flag it.
          ovf_d = 1'b1;
        end
      end
      StDrain: begin
        if (we_cl) begin
          ovf_d = 1'b1;
        end
        if (next_cl) begin
          idx_d = idx_q + 1'b1;
          if (at_last) begin
            state_d = StFill;
          end
        end
      end
      default: begin
        state_d = StFill;
      end
    endcase
  end

  // Outputs: all derived from registered state only, no din-to-dout bypass.
  always_comb begin
    full_cl    = at_last;
    dout       = slot_q[idx_q];
    imem_waddr = {line_addr_q, idx_q};
    draining   = (state_q == StDrain);
    ovf_err    = ovf_q;
  end

endmodule

// File: tb/tb_cache_line_buffer.sv
// Directed bench for cache_line_buffer with WORDS=4, LINE_AW=28, DATA_W=32.
module tb_cache_line_buffer;

  logic        clk;
  logic        reset;
  logic        clr;
  logic        we_cl;
  logic        next_cl;
  logic [31:0] din;
  logic [27:0] miss_line_addr;
  logic        full_cl;
  logic [31:0] dout;
  logic [29:0] imem_waddr;
  logic        draining;
  logic        ovf_err;

  int vec_cnt;
  int err_cnt;

  cache_line_buffer #(
    .DATA_W (32),
    .WORDS  (4),
    .LINE_AW(28)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .clr           (clr),
    .we_cl         (we_cl),
    .next_cl       (next_cl),
    .din           (din),
    .miss_line_addr(miss_line_addr),
    .full_cl       (full_cl),
    .dout          (dout),
    .imem_waddr    (imem_waddr),
    .draining      (draining),
    .ovf_err       (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of strobes at the falling edge; the DUT samples them on the next rise.
  task automatic drive(input logic we, input logic nx, input logic [31:0] d,
                       input logic [27:0] a);
    @(negedge clk);
    we_cl          = we;
    next_cl        = nx;
    din            = d;
    miss_line_addr = a;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 28'h0);
  endtask

  task automatic fill_line(input logic [27:0] a, input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, base + 32'(i), a);
      check("fill_full", full_cl, (i == 3));
      check("fill_draining", draining, 1'b0);
    end
  endtask

  // Drain with next_cl held; waddr_base is the expected {line, 2'b00}.
  task automatic drain_line(input logic [29:0] waddr_base, input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'h0, 28'h0);
      check("drain_draining", draining, 1'b1);
      check("drain_dout", dout, base + 32'(i));
      check("drain_waddr", imem_waddr, waddr_base + 30'(i));
      check("drain_full", full_cl, (i == 3));
    end
  endtask

  initial begin
    vec_cnt        = 0;
    err_cnt        = 0;
    reset          = 1'b1;
    clr            = 1'b0;
    we_cl          = 1'b0;
    next_cl        = 1'b0;
    din            = '0;
    miss_line_addr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_full", full_cl, 1'b0);
    check("rst_dout", dout, 32'h0);
    check("rst_waddr", imem_waddr, 30'h0);
    check("rst_draining", draining, 1'b0);
    check("rst_ovf", ovf_err, 1'b0);

    // 1: fill A0..A3 with 1-cycle gaps.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'hA0 + 32'(i), 28'h123);
      check("t1_full", full_cl, (i == 3));
      check("t1_draining", draining, 1'b0);
      idle();
      if (i < 3) check("t1_gap_draining", draining, 1'b0);
    end
    check("t1_draining_after", draining, 1'b1);
    check("t1_first_dout", dout, 32'hA0);

    // 2: drain A0..A3 at 0x48C..0x48F.
    drain_line(30'h48C, 32'hA0);
    idle();
    check("t2_draining_end", draining, 1'b0);
    check("t2_idx0", imem_waddr, 30'h48C);
    check("t2_full_end", full_cl, 1'b0);
    check("t2_ovf", ovf_err, 1'b0);

    // 3: two back-to-back lines; second must show only B data.
    fill_line(28'h123, 32'hC0);
    drain_line(30'h48C, 32'hC0);
    fill_line(28'h200, 32'hB0);
    drain_line(30'h800, 32'hB0);
    idle();
    check("t3_draining_end", draining, 1'b0);

    // 4: clr after two fill writes, then a clean refill.
    drive(1'b1, 1'b1, 32'hE0, 28'h0FF);
    drive(1'b1, 1'b1, 32'hE1, 28'h0FF);
    @(negedge clk);
    we_cl   = 1'b0;
    next_cl = 1'b0;
    clr     = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t4_waddr", imem_waddr, 30'h0);
    check("t4_full", full_cl, 1'b0);
    check("t4_dout", dout, 32'h0);
    check("t4_draining", draining, 1'b0);
    fill_line(28'h0AB, 32'hF0);
    drain_line(30'h2AC, 32'hF0);

    // 5/6: we_cl during drain flags ovf without moving idx; reset mid-drain clears all.
    fill_line(28'h010, 32'h50);
    drive(1'b0, 1'b1, 32'h0, 28'h0);
    drive(1'b0, 1'b1, 32'h0, 28'h0);
    drive(1'b1, 1'b0, 32'hDEAD, 28'h0);
    check("t5_idx2", imem_waddr, 30'h042);
    check("t5_dout2", dout, 32'h52);
    idle();
    check("t6_ovf_drain", ovf_err, 1'b1);
    check("t6_idx_hold", imem_waddr, 30'h042);
    check("t6_slot_hold", dout, 32'h52);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_draining", draining, 1'b0);
    check("t5_waddr", imem_waddr, 30'h0);
    check("t5_dout", dout, 32'h0);
    check("t5_ovf", ovf_err, 1'b0);

    // 6: next_cl alone in FILL; we_cl alone overwrites without advancing.
    drive(1'b1, 1'b1, 32'h70, 28'h050);
    drive(1'b0, 1'b1, 32'h0, 28'h0);
    idle();
    check("t6_ovf_fill", ovf_err, 1'b1);
    check("t6_fill_idx", imem_waddr, 30'h141);
    drive(1'b1, 1'b0, 32'hBAD, 28'h0);
    idle();
    check("t6_we_only_idx", imem_waddr, 30'h141);
    drive(1'b1, 1'b1, 32'h71, 28'h0);
    drive(1'b1, 1'b1, 32'h72, 28'h0);
    drive(1'b1, 1'b1, 32'h73, 28'h0);
    check("t6_full", full_cl, 1'b1);
    drain_line(30'h140, 32'h70);
    idle();
    check("t6_ovf_sticky", ovf_err, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
